// File: rtl/counter_pkg.sv
// Shared definitions for the modulo up-counter: FSM state encoding and the
// width / saturation limit of the wrap event counter.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int               WRAP_CNT_W   = 8;
    localparam logic [WRAP_CNT_W-1:0] WRAP_CNT_MAX = 8'd255;

endpackage : counter_pkg

// File: rtl/sat_counter.sv
// Saturating event counter: increments on inc, sticks at WRAP_CNT_MAX,
// returns to zero on a synchronous clear or reset.
module sat_counter
    import counter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  inc,
    output logic [WRAP_CNT_W-1:0] cnt
);

    logic [WRAP_CNT_W-1:0] cnt_q;
    logic [WRAP_CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != WRAP_CNT_MAX)) begin
            cnt_d = cnt_q + {{(WRAP_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Count register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : sat_counter

// File: rtl/up_counter_mod.sv
// Modulo-MODULO up-counter with load, clear, wrap/one-shot modes and a
// saturating wrap counter. Per-cycle priority is rst > clear > load > en.
// MODULO must lie in 2..2**WIDTH.
// State is exposed on state_dbg so checkers can follow the FSM directly.
module up_counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int MODULO = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clear,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  one_shot,
    output logic [WIDTH-1:0]      q,
    output logic                  wrap,
    output logic                  done,
    output logic                  load_err,
    output logic [WRAP_CNT_W-1:0] wrap_cnt,
    output state_e                state_dbg
);

    // Terminal count, and MODULO widened by one bit so that 2**WIDTH fits.
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULO - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);
    localparam logic [WIDTH-1:0] ONE_Q   = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             load_err_q, load_err_d;
    logic             load_ok;

    assign load_ok = ({1'b0, load_val} < MOD_EXT);

    // Next-state and next-output computation with clear > load > en priority.
    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (clear) begin
            q_d     = '0;
            state_d = IDLE;
        end else if (load) begin
            state_d = IDLE;
            if (load_ok) begin
                q_d = load_val;
            end else begin
                q_d        = MAX_Q;
                load_err_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE, COUNT: begin
                    if (en) begin
                        if (q_q < MAX_Q) begin
                            q_d     = q_q + ONE_Q;
                            state_d = COUNT;
                        end else if (one_shot) begin
                            // Hold at terminal count; no wrap pulse.
                            state_d = DONE;
                        end else begin
                            q_d     = '0;
                            wrap_d  = 1'b1;
                            state_d = COUNT;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                DONE: begin
                    // Only clear, load or rst leave DONE; en is ignored.
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        done_d = (state_d == DONE);
    end

    // FSM state and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            q_q        <= '0;
            wrap_q     <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            wrap_q     <= wrap_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    // Wrap events are counted in the same edge that q returns to zero.
    sat_counter u_wrap_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (wrap_d),
        .cnt (wrap_cnt)
    );

    assign q         = q_q;
    assign wrap      = wrap_q;
    assign done      = done_q;
    assign load_err  = load_err_q;
    assign state_dbg = state_q;

endmodule : up_counter_mod

// File: tb/tb_up_counter_mod.sv
// Directed bench for up_counter_mod: three instances (MODULO 8, 6 and 2)
// share one set of inputs; each scenario task checks the relevant instance.
module tb_up_counter_mod;
    import counter_pkg::*;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clear;
    logic       load;
    logic [2:0] load_val;
    logic       one_shot;

    logic [2:0] q8, q6;
    logic [0:0] q2;
    logic       wrap8, wrap6, wrap2;
    logic       done8, done6, done2;
    logic       lerr8, lerr6, lerr2;
    logic [7:0] wcnt8, wcnt6, wcnt2;
    state_e     st8, st6, st2;

    int n_cmp;
    int n_err;

    logic [2:0] exp_q[$];

    up_counter_mod #(.WIDTH(3), .MODULO(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .load(load),
        .load_val(load_val), .one_shot(one_shot), .q(q8), .wrap(wrap8),
        .done(done8), .load_err(lerr8), .wrap_cnt(wcnt8), .state_dbg(st8)
    );

    up_counter_mod #(.WIDTH(3), .MODULO(6)) dut6 (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .load(load),
        .load_val(load_val), .one_shot(one_shot), .q(q6), .wrap(wrap6),
        .done(done6), .load_err(lerr6), .wrap_cnt(wcnt6), .state_dbg(st6)
    );

    up_counter_mod #(.WIDTH(1), .MODULO(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .load(load),
        .load_val(load_val[0:0]), .one_shot(one_shot), .q(q2), .wrap(wrap2),
        .done(done2), .load_err(lerr2), .wrap_cnt(wcnt2), .state_dbg(st2)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst      = 1'b0;
        en       = 1'b0;
        clear    = 1'b0;
        load     = 1'b0;
        load_val = 3'd0;
        one_shot = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (q8 !== 3'd0)    begin n_err++; $display("FAIL reset_q8: got %0d want 0", q8); end
        n_cmp++; if (q6 !== 3'd0)    begin n_err++; $display("FAIL reset_q6: got %0d want 0", q6); end
        n_cmp++; if (q2 !== 1'b0)    begin n_err++; $display("FAIL reset_q2: got %0d want 0", q2); end
        n_cmp++; if ({wrap8, done8, lerr8} !== 3'b000) begin n_err++; $display("FAIL reset_flags8: got %b want 000", {wrap8, done8, lerr8}); end
        n_cmp++; if (wcnt8 !== 8'd0) begin n_err++; $display("FAIL reset_wcnt8: got %0d want 0", wcnt8); end
        n_cmp++; if (st8 !== IDLE)   begin n_err++; $display("FAIL reset_state8: got %0d want %0d", st8, IDLE); end
    endtask

    // rst for one cycle then en=1 for ten cycles on MODULO 8.
    task automatic test_wrap();
        do_reset();
        en = 1'b1;
        for (int v = 1; v <= 10; v++) exp_q.push_back(3'(v % 8));
        for (int i = 0; i < 10; i++) begin
            logic [2:0] e;
            tick();
            e = exp_q.pop_front();
            n_cmp++; if (q8 !== e) begin n_err++; $display("FAIL wrap_q[%0d]: got %0d want %0d", i, q8, e); end
            n_cmp++; if (wrap8 !== (e == 3'd0)) begin n_err++; $display("FAIL wrap_pulse[%0d]: got %0b want %0b", i, wrap8, (e == 3'd0)); end
        end
        n_cmp++; if (wcnt8 !== 8'd1) begin n_err++; $display("FAIL wrap_cnt: got %0d want 1", wcnt8); end
        n_cmp++; if (st8 !== COUNT)  begin n_err++; $display("FAIL wrap_state: got %0d want %0d", st8, COUNT); end
    endtask

    // One-shot on MODULO 6, then rst while DONE with a coincident load.
    task automatic test_one_shot();
        do_reset();
        en = 1'b1;
        one_shot = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_cmp++; if (q6 !== 3'(i)) begin n_err++; $display("FAIL os_q[%0d]: got %0d want %0d", i, q6, i); end
            n_cmp++; if (done6 !== 1'b0 || wrap6 !== 1'b0) begin n_err++; $display("FAIL os_flags[%0d]: got done=%0b wrap=%0b want 0 0", i, done6, wrap6); end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (q6 !== 3'd5)  begin n_err++; $display("FAIL os_hold_q[%0d]: got %0d want 5", i, q6); end
            n_cmp++; if (done6 !== 1'b1 || st6 !== DONE) begin n_err++; $display("FAIL os_done[%0d]: got done=%0b st=%0d want 1 %0d", i, done6, st6, DONE); end
            n_cmp++; if (wrap6 !== 1'b0) begin n_err++; $display("FAIL os_wrap[%0d]: got %0b want 0", i, wrap6); end
        end
        rst = 1'b1;
        load = 1'b1;
        load_val = 3'd3;
        tick();
        rst = 1'b0;
        load = 1'b0;
        n_cmp++; if (q6 !== 3'd0)   begin n_err++; $display("FAIL done_rst_q: got %0d want 0", q6); end
        n_cmp++; if (done6 !== 1'b0 || wcnt6 !== 8'd0) begin n_err++; $display("FAIL done_rst_flags: got done=%0b wcnt=%0d want 0 0", done6, wcnt6); end
        n_cmp++; if (st6 !== IDLE)  begin n_err++; $display("FAIL done_rst_state: got %0d want %0d", st6, IDLE); end
    endtask

    // Loads on MODULO 6: out of range, boundary, in range, and leaving DONE.
    task automatic test_load();
        do_reset();
        load = 1'b1;
        load_val = 3'd7;
        tick();
        n_cmp++; if (q6 !== 3'd5 || lerr6 !== 1'b1) begin n_err++; $display("FAIL load7: got q=%0d err=%0b want 5 1", q6, lerr6); end
        load = 1'b0;
        tick();
        n_cmp++; if (q6 !== 3'd5 || lerr6 !== 1'b0) begin n_err++; $display("FAIL load7_after: got q=%0d err=%0b want 5 0", q6, lerr6); end
        load = 1'b1;
        load_val = 3'd3;
        tick();
        n_cmp++; if (q6 !== 3'd3 || lerr6 !== 1'b0) begin n_err++; $display("FAIL load3: got q=%0d err=%0b want 3 0", q6, lerr6); end
        load_val = 3'd6;
        tick();
        n_cmp++; if (q6 !== 3'd5 || lerr6 !== 1'b1) begin n_err++; $display("FAIL load6: got q=%0d err=%0b want 5 1", q6, lerr6); end
        load_val = 3'd3;
        tick();
        load = 1'b0;
        en = 1'b1;
        one_shot = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (q6 !== 3'd5 || st6 !== DONE) begin n_err++; $display("FAIL load_to_done: got q=%0d st=%0d want 5 %0d", q6, st6, DONE); end
        load = 1'b1;
        load_val = 3'd1;
        tick();
        load = 1'b0;
        en = 1'b0;
        n_cmp++; if (q6 !== 3'd1 || done6 !== 1'b0 || st6 !== IDLE) begin n_err++; $display("FAIL load_exit_done: got q=%0d done=%0b st=%0d want 1 0 %0d", q6, done6, st6, IDLE); end
    endtask

    // Priority on MODULO 8: load over en, clear over load, en low -> IDLE.
    task automatic test_priority();
        do_reset();
        en = 1'b1;
        load = 1'b1;
        load_val = 3'd2;
        tick();
        n_cmp++; if (q8 !== 3'd2 || st8 !== IDLE) begin n_err++; $display("FAIL load_wins: got q=%0d st=%0d want 2 %0d", q8, st8, IDLE); end
        load = 1'b0;
        tick();
        n_cmp++; if (q8 !== 3'd3 || st8 !== COUNT) begin n_err++; $display("FAIL count_after_load: got q=%0d st=%0d want 3 %0d", q8, st8, COUNT); end
        en = 1'b0;
        tick();
        n_cmp++; if (q8 !== 3'd3 || st8 !== IDLE) begin n_err++; $display("FAIL en_low_idle: got q=%0d st=%0d want 3 %0d", q8, st8, IDLE); end
        clear = 1'b1;
        load = 1'b1;
        load_val = 3'd4;
        en = 1'b1;
        tick();
        clear = 1'b0;
        load = 1'b0;
        en = 1'b0;
        n_cmp++; if (q8 !== 3'd0 || st8 !== IDLE) begin n_err++; $display("FAIL clear_wins: got q=%0d st=%0d want 0 %0d", q8, st8, IDLE); end
    endtask

    // one_shot raised while already at terminal count; DONE ignores en low.
    task automatic test_one_shot_change();
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        n_cmp++; if (q8 !== 3'd7) begin n_err++; $display("FAIL osc_q7: got %0d want 7", q8); end
        one_shot = 1'b1;
        tick();
        n_cmp++; if (q8 !== 3'd7 || done8 !== 1'b1 || wrap8 !== 1'b0) begin n_err++; $display("FAIL osc_done: got q=%0d done=%0b wrap=%0b want 7 1 0", q8, done8, wrap8); end
        en = 1'b0;
        tick();
        n_cmp++; if (st8 !== DONE || done8 !== 1'b1) begin n_err++; $display("FAIL osc_stay: got st=%0d done=%0b want %0d 1", st8, done8, DONE); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        one_shot = 1'b0;
        n_cmp++; if (q8 !== 3'd0 || done8 !== 1'b0 || st8 !== IDLE) begin n_err++; $display("FAIL osc_clear: got q=%0d done=%0b st=%0d want 0 0 %0d", q8, done8, st8, IDLE); end
    endtask

    // 300 wraps on MODULO 2: wrap_cnt saturates at 255, clear zeroes it.
    task automatic test_saturation();
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 600; i++) begin
            tick();
            if (i == 508) begin
                n_cmp++; if (wcnt2 !== 8'd254) begin n_err++; $display("FAIL sat_254: got %0d want 254", wcnt2); end
            end
            if (i == 510) begin
                n_cmp++; if (wcnt2 !== 8'd255) begin n_err++; $display("FAIL sat_255: got %0d want 255", wcnt2); end
            end
        end
        n_cmp++; if (wcnt2 !== 8'd255) begin n_err++; $display("FAIL sat_hold: got %0d want 255", wcnt2); end
        n_cmp++; if (q2 !== 1'b0 || wrap2 !== 1'b1) begin n_err++; $display("FAIL sat_last_wrap: got q=%0d wrap=%0b want 0 1", q2, wrap2); end
        en = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_cmp++; if (wcnt2 !== 8'd0 || wrap2 !== 1'b0 || lerr2 !== 1'b0) begin n_err++; $display("FAIL sat_clear: got wcnt=%0d wrap=%0b err=%0b want 0 0 0", wcnt2, wrap2, lerr2); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle_inputs();
        test_reset();
        test_wrap();
        test_one_shot();
        test_load();
        test_priority();
        test_one_shot_change();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_up_counter_mod
